dca_matrix_reorder_engine: RTL and testbench



---
 rtl/dca_matrix_reorder_engine_if.sv | 52 +++++
 rtl/dca_matrix_reorder_engine.sv | 161 ++++++++++++++++
 tb/tb_dca_matrix_reorder_engine.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dca_matrix_reorder_engine_if.sv
// Port bundle of the matrix reorder engine: control FIFOs, status/log and both matrix LSU ports.
// master = surrounding subsystem (FIFOs, LSUs), slave = the reorder engine itself.
interface dca_matrix_reorder_engine_if #(
  parameter int BW_ADDR     = 32,
  parameter int MATRIX_SIZE = 8,
  parameter int BW_SCALAR   = 16
);
  logic                               clear_request;
  logic                               clear_finish;
  logic [1:0]                         core_status;
  logic                               inst_fifo_rready;
  logic [2*BW_ADDR+1:0]               inst_fifo_rdata;
  logic                               inst_fifo_rrequest;
  logic                               operation_finish;
  logic                               log_fifo_wready;
  logic                               log_fifo_wrequest;
  logic [31:0]                        log_fifo_wdata;
  logic                               mi_inst_wvalid;
  logic                               mi_inst_wready;
  logic [BW_ADDR-1:0]                 mi_inst_wdata;
  logic                               mi_execute_finish;
  logic                               mi_row_wvalid;
  logic                               mi_row_wlast;
  logic [MATRIX_SIZE*BW_SCALAR-1:0]   mi_row_wdata;
  logic                               mi_row_wready;
  logic                               mo_inst_wvalid;
  logic                               mo_inst_wready;
  logic [BW_ADDR-1:0]                 mo_inst_wdata;
  logic                               mo_execute_finish;
  logic                               mo_row_rvalid;
  logic                               mo_row_rlast;
  logic                               mo_row_rready;
  logic [MATRIX_SIZE*BW_SCALAR-1:0]   mo_row_rdata;

  modport master (
    output clear_request, inst_fifo_rready, inst_fifo_rdata, log_fifo_wready,
           mi_inst_wready, mi_execute_finish, mi_row_wvalid, mi_row_wlast, mi_row_wdata,
           mo_inst_wready, mo_execute_finish, mo_row_rvalid, mo_row_rlast,
    input  clear_finish, core_status, inst_fifo_rrequest, operation_finish,
           log_fifo_wrequest, log_fifo_wdata, mi_inst_wvalid, mi_inst_wdata, mi_row_wready,
           mo_inst_wvalid, mo_inst_wdata, mo_row_rready, mo_row_rdata
  );

  modport slave (
    input  clear_request, inst_fifo_rready, inst_fifo_rdata, log_fifo_wready,
           mi_inst_wready, mi_execute_finish, mi_row_wvalid, mi_row_wlast, mi_row_wdata,
           mo_inst_wready, mo_execute_finish, mo_row_rvalid, mo_row_rlast,
    output clear_finish, core_status, inst_fifo_rrequest, operation_finish,
           log_fifo_wrequest, log_fifo_wdata, mi_inst_wvalid, mi_inst_wdata, mi_row_wready,
           mo_inst_wvalid, mo_inst_wdata, mo_row_rready, mo_row_rdata
  );
endinterface

// File: rtl/dca_matrix_reorder_engine.sv
// Matrix reorder engine: loads an N x N tile from MI, streams it to MO as copy/transpose/row-/column-reverse.
// Optional per-tile logging is enabled with the macro DCA_MATRIX_REORDER_LOG_EN.
module dca_matrix_reorder_engine #(
  parameter int BW_ADDR     = 32,
  parameter int MATRIX_SIZE = 8,
  parameter int BW_SCALAR   = 16
) (
  input logic                     clk,
  input logic                     rstnn,
  dca_matrix_reorder_engine_if.slave bus
);
  localparam int N      = MATRIX_SIZE;
  localparam int ROW_W  = $clog2(N);
  localparam int BW_ROW = N * BW_SCALAR;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(N - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_POP, ST_ISSUE_LD, ST_LOAD, ST_ISSUE_ST, ST_STORE, ST_WAIT_ST, ST_DONE
  } state_t;

  state_t             state, state_next;
  logic [ROW_W-1:0]   row;
  logic               error;
  logic [1:0]         mode;
  logic [BW_ADDR-1:0] src_addr, dst_addr;
  logic               clear_finish_q;
  logic [BW_ROW-1:0]  tile_buf [N];
  logic [BW_ROW-1:0]  reorder_row;
  logic               at_last, ld_beat, ld_final, st_beat, st_final, done_fire;
  logic [1:0]         unused_inputs;

  assign at_last  = (row == LAST_ROW);
  assign ld_beat  = (state == ST_LOAD) && bus.mi_row_wvalid;
  assign ld_final = ld_beat && (at_last || bus.mi_row_wlast);
  assign st_beat  = (state == ST_STORE) && bus.mo_row_rvalid;
  assign st_final = st_beat && (at_last || bus.mo_row_rlast);

`ifdef DCA_MATRIX_REORDER_LOG_EN
  logic [15:0] tile_count;

  // DONE only completes once the log word has been accepted
  assign done_fire              = (state == ST_DONE) && bus.log_fifo_wready && !bus.clear_request;
  assign bus.log_fifo_wrequest  = done_fire;
  assign bus.log_fifo_wdata     = (state == ST_DONE) ? {error, mode, 13'b0, tile_count} : 32'd0;
  assign unused_inputs          = {bus.mi_execute_finish, 1'b0};

  always_ff @(posedge clk) begin
    if (rstnn)          tile_count <= '0;
    else if (done_fire) tile_count <= tile_count + 16'd1;
  end
`else
  assign done_fire              = (state == ST_DONE) && !bus.clear_request;
  assign bus.log_fifo_wrequest  = 1'b0;
  assign bus.log_fifo_wdata     = 32'd0;
  assign unused_inputs          = {bus.mi_execute_finish, bus.log_fifo_wready};
`endif

  always_ff @(posedge clk) begin
    if (rstnn) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next              = state;
    bus.inst_fifo_rrequest  = 1'b0;
    bus.mi_inst_wvalid      = 1'b0;
    bus.mi_row_wready       = 1'b0;
    bus.mo_inst_wvalid      = 1'b0;
    bus.mo_row_rready       = 1'b0;
    bus.operation_finish    = 1'b0;
    case (state)
      ST_IDLE:     if (bus.inst_fifo_rready) state_next = ST_POP;
      ST_POP: begin
        bus.inst_fifo_rrequest = 1'b1;
        state_next             = ST_ISSUE_LD;
      end
      ST_ISSUE_LD: begin
        bus.mi_inst_wvalid = 1'b1;
        if (bus.mi_inst_wready) state_next = ST_LOAD;
      end
      ST_LOAD: begin
        bus.mi_row_wready = 1'b1;
        if (ld_final) state_next = ST_ISSUE_ST;
      end
      ST_ISSUE_ST: begin
        bus.mo_inst_wvalid = 1'b1;
        if (bus.mo_inst_wready) state_next = ST_STORE;
      end
      ST_STORE: begin
        bus.mo_row_rready = 1'b1;
        if (st_final) state_next = ST_WAIT_ST;
      end
      ST_WAIT_ST:  if (bus.mo_execute_finish) state_next = ST_DONE;
      ST_DONE: begin
        bus.operation_finish = done_fire;
        if (done_fire) state_next = ST_IDLE;
      end
      default:     state_next = ST_IDLE;
    endcase
    // abort overrides whatever the current state wanted
    if (bus.clear_request) state_next = ST_IDLE;
  end

  // Row counter, error flag and latched instruction; a row beat checks that 'last' lines up with row N-1
  always_ff @(posedge clk) begin
    if (rstnn) begin
      row            <= '0;
      error          <= 1'b0;
      mode           <= 2'd0;
      src_addr       <= '0;
      dst_addr       <= '0;
      clear_finish_q <= 1'b0;
    end else begin
      clear_finish_q <= bus.clear_request;
      if (bus.clear_request) begin
        row   <= '0;
        error <= 1'b0;
      end else begin
        if (state == ST_POP) begin
          mode     <= bus.inst_fifo_rdata[2*BW_ADDR+1 -: 2];
          dst_addr <= bus.inst_fifo_rdata[2*BW_ADDR-1 -: BW_ADDR];
          src_addr <= bus.inst_fifo_rdata[BW_ADDR-1:0];
          error    <= 1'b0;
        end
        if (ld_beat) begin
          row <= ld_final ? '0 : row + ROW_W'(1);
          if (bus.mi_row_wlast != at_last) error <= 1'b1;
        end
        if (st_beat) begin
          row <= st_final ? '0 : row + ROW_W'(1);
          if (bus.mo_row_rlast != at_last) error <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ld_beat && !bus.clear_request && !rstnn) tile_buf[row] <= bus.mi_row_wdata;
  end

  // Output row is a pure mux of the buffer; only driven while streaming so it idles at zero
  always_comb begin
    reorder_row = '0;
    if (state == ST_STORE) begin
      for (int c = 0; c < N; c++) begin
        case (mode)
          2'd0:    reorder_row[c*BW_SCALAR +: BW_SCALAR] = tile_buf[row][c*BW_SCALAR +: BW_SCALAR];
          2'd1:    reorder_row[c*BW_SCALAR +: BW_SCALAR] = tile_buf[ROW_W'(c)][int'(row)*BW_SCALAR +: BW_SCALAR];
          2'd2:    reorder_row[c*BW_SCALAR +: BW_SCALAR] = tile_buf[LAST_ROW - row][c*BW_SCALAR +: BW_SCALAR];
          default: reorder_row[c*BW_SCALAR +: BW_SCALAR] = tile_buf[row][(N-1-c)*BW_SCALAR +: BW_SCALAR];
        endcase
      end
    end
  end

  assign bus.mo_row_rdata  = reorder_row;
  assign bus.mi_inst_wdata = src_addr;
  assign bus.mo_inst_wdata = dst_addr;
  assign bus.core_status   = {error, state != ST_IDLE};
  assign bus.clear_finish  = clear_finish_q;
endmodule

// File: tb/tb_dca_matrix_reorder_engine.sv
// Self-checking bench for dca_matrix_reorder_engine: acts as both LSUs and the control FIFOs,
// with a scoreboard of expected output rows; build with DCA_MATRIX_REORDER_LOG_EN to cover logging.
module tb_dca_matrix_reorder_engine;
  localparam int BW_ADDR = 32;
  localparam int N       = 8;
  localparam int BW_S    = 16;
  localparam int BW_ROW  = N * BW_S;

  logic clk = 1'b0;
  logic rstnn;
  always #5 clk = ~clk;

  dca_matrix_reorder_engine_if #(.BW_ADDR(BW_ADDR), .MATRIX_SIZE(N), .BW_SCALAR(BW_S)) bus ();

  dca_matrix_reorder_engine #(.BW_ADDR(BW_ADDR), .MATRIX_SIZE(N), .BW_SCALAR(BW_S)) dut (
    .clk   (clk),
    .rstnn (rstnn),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int log_count = 0;
  logic [BW_S-1:0]   mat [N][N];
  logic [BW_ROW-1:0] exp_q [$];
  logic              chk_q [$];

  function automatic logic [BW_ROW-1:0] pack_in(input int r);
    logic [BW_ROW-1:0] v;
    for (int c = 0; c < N; c++) v[c*BW_S +: BW_S] = mat[r][c];
    return v;
  endfunction

  // Reference reorder: element (r,c) of the output tile for each mode
  function automatic logic [BW_ROW-1:0] exp_row(input logic [1:0] m, input int r);
    logic [BW_ROW-1:0] v;
    for (int c = 0; c < N; c++) begin
      case (m)
        2'd0:    v[c*BW_S +: BW_S] = mat[r][c];
        2'd1:    v[c*BW_S +: BW_S] = mat[c][r];
        2'd2:    v[c*BW_S +: BW_S] = mat[N-1-r][c];
        default: v[c*BW_S +: BW_S] = mat[r][N-1-c];
      endcase
    end
    return v;
  endfunction

  // Drives one full tile; last_at is the load beat carrying wlast, clear_at (>=0) aborts in STORE
  task automatic run_tile(input logic [1:0] m, input logic [31:0] s, input logic [31:0] d,
                          input int seed, input int last_at, input int ld_stall, input int st_stall,
                          input int log_stall, input int clear_at);
    int k;
    logic exp_err;
    logic [BW_ROW-1:0] ev;
    logic ec;
    exp_err = (last_at != N-1);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) mat[r][c] = 16'(r*N + c + seed);
    bus.inst_fifo_rdata  = {m, d, s};
    bus.inst_fifo_rready = 1'b1;
    k = 0;
    while (bus.inst_fifo_rrequest !== 1'b1 && k < 20) begin @(posedge clk); #1; k++; end
    checks++;
    if (bus.inst_fifo_rrequest !== 1'b1) begin
      $display("[TB] FAIL pop_timeout got %b expected 1", bus.inst_fifo_rrequest); errors++;
    end
    @(posedge clk); #1;
    bus.inst_fifo_rready = 1'b0;
    checks++;
    if (bus.core_status !== 2'b01) begin
      $display("[TB] FAIL status_after_pop got %b expected 01", bus.core_status); errors++;
    end
    for (int i = 0; i <= ld_stall; i++) begin
      checks++;
      if (bus.mi_inst_wvalid !== 1'b1 || bus.mi_inst_wdata !== s) begin
        $display("[TB] FAIL mi_inst got v=%b a=%h expected v=1 a=%h", bus.mi_inst_wvalid, bus.mi_inst_wdata, s); errors++;
      end
      if (i == ld_stall) bus.mi_inst_wready = 1'b1;
      @(posedge clk); #1;
    end
    bus.mi_inst_wready = 1'b0;
    for (int r = 0; r <= last_at; r++) begin
      bus.mi_row_wvalid = 1'b1;
      bus.mi_row_wdata  = pack_in(r);
      bus.mi_row_wlast  = (r == last_at);
      checks++;
      if (bus.mi_row_wready !== 1'b1) begin
        $display("[TB] FAIL mi_row_wready row %0d got %b expected 1", r, bus.mi_row_wready); errors++;
      end
      @(posedge clk); #1;
    end
    bus.mi_row_wvalid = 1'b0;
    bus.mi_row_wlast  = 1'b0;
    // rows never loaded after an early wlast are don't-care (early test uses mode 0 only)
    for (int r = 0; r < N; r++) begin
      exp_q.push_back(exp_row(m, r));
      chk_q.push_back(r <= last_at);
    end
    for (int i = 0; i <= st_stall; i++) begin
      checks++;
      if (bus.mo_inst_wvalid !== 1'b1 || bus.mo_inst_wdata !== d) begin
        $display("[TB] FAIL mo_inst got v=%b a=%h expected v=1 a=%h", bus.mo_inst_wvalid, bus.mo_inst_wdata, d); errors++;
      end
      if (i == st_stall) bus.mo_inst_wready = 1'b1;
      @(posedge clk); #1;
    end
    bus.mo_inst_wready = 1'b0;
    for (int r = 0; r < N; r++) begin
      bus.mo_row_rvalid = 1'b1;
      bus.mo_row_rlast  = (r == N-1);
      if (r == clear_at) bus.clear_request = 1'b1;
      checks++;
      if (bus.mo_row_rready !== 1'b1) begin
        $display("[TB] FAIL mo_row_rready row %0d got %b expected 1", r, bus.mo_row_rready); errors++;
      end
      ev = exp_q.pop_front();
      ec = chk_q.pop_front();
      if (ec) begin
        checks++;
        if (bus.mo_row_rdata !== ev) begin
          $display("[TB] FAIL row_data mode %0d row %0d got %h expected %h", m, r, bus.mo_row_rdata, ev); errors++;
        end
      end
      @(posedge clk); #1;
      if (r == clear_at) begin
        bus.clear_request = 1'b0;
        bus.mo_row_rvalid = 1'b0;
        bus.mo_row_rlast  = 1'b0;
        checks++;
        if (bus.core_status !== 2'b00 || bus.mo_row_rready !== 1'b0 || bus.clear_finish !== 1'b1 || bus.operation_finish !== 1'b0) begin
          $display("[TB] FAIL clear_abort got st=%b rr=%b cf=%b of=%b expected st=00 rr=0 cf=1 of=0",
                   bus.core_status, bus.mo_row_rready, bus.clear_finish, bus.operation_finish); errors++;
        end
        @(posedge clk); #1;
        checks++;
        if (bus.clear_finish !== 1'b0 || bus.operation_finish !== 1'b0) begin
          $display("[TB] FAIL clear_pulse_width got cf=%b of=%b expected cf=0 of=0", bus.clear_finish, bus.operation_finish); errors++;
        end
        exp_q.delete();
        chk_q.delete();
        return;
      end
    end
    bus.mo_row_rvalid = 1'b0;
    bus.mo_row_rlast  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (bus.operation_finish !== 1'b0 || bus.core_status[0] !== 1'b1) begin
        $display("[TB] FAIL wait_store got of=%b busy=%b expected of=0 busy=1", bus.operation_finish, bus.core_status[0]); errors++;
      end
      @(posedge clk); #1;
    end
    bus.log_fifo_wready   = (log_stall == 0);
    bus.mo_execute_finish = 1'b1;
    @(posedge clk); #1;
    bus.mo_execute_finish = 1'b0;
`ifdef DCA_MATRIX_REORDER_LOG_EN
    for (int i = 0; i < log_stall; i++) begin
      checks++;
      if (bus.operation_finish !== 1'b0 || bus.log_fifo_wrequest !== 1'b0) begin
        $display("[TB] FAIL log_stall cycle %0d got of=%b wr=%b expected 0 0", i, bus.operation_finish, bus.log_fifo_wrequest); errors++;
      end
      @(posedge clk); #1;
    end
`endif
    bus.log_fifo_wready = 1'b1;
    checks++;
    if (bus.operation_finish !== 1'b1 || bus.core_status !== {exp_err, 1'b1}) begin
      $display("[TB] FAIL done got of=%b st=%b expected of=1 st=%b1", bus.operation_finish, bus.core_status, exp_err); errors++;
    end
    checks++;
`ifdef DCA_MATRIX_REORDER_LOG_EN
    if (bus.log_fifo_wrequest !== 1'b1 || bus.log_fifo_wdata !== {exp_err, m, 13'b0, 16'(log_count)}) begin
      $display("[TB] FAIL log_word got wr=%b d=%h expected wr=1 d=%h", bus.log_fifo_wrequest, bus.log_fifo_wdata,
               {exp_err, m, 13'b0, 16'(log_count)}); errors++;
    end
    log_count++;
`else
    if (bus.log_fifo_wrequest !== 1'b0 || bus.log_fifo_wdata !== 32'd0) begin
      $display("[TB] FAIL log_disabled got wr=%b d=%h expected 0 0", bus.log_fifo_wrequest, bus.log_fifo_wdata); errors++;
    end
`endif
    @(posedge clk); #1;
    checks++;
    if (bus.core_status !== {exp_err, 1'b0} || bus.operation_finish !== 1'b0) begin
      $display("[TB] FAIL idle_after_done got st=%b of=%b expected st=%b0 of=0", bus.core_status, bus.operation_finish, exp_err); errors++;
    end
  endtask

  task automatic test_reset();
    rstnn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.core_status, bus.inst_fifo_rrequest, bus.operation_finish, bus.clear_finish, bus.mi_inst_wvalid,
         bus.mo_inst_wvalid, bus.mi_row_wready, bus.mo_row_rready, bus.log_fifo_wrequest} !== 10'd0 ||
        bus.log_fifo_wdata !== 32'd0 || bus.mi_inst_wdata !== 32'd0 || bus.mo_inst_wdata !== 32'd0 ||
        bus.mo_row_rdata !== '0) begin
      $display("[TB] FAIL reset_outputs got st=%b rq=%b of=%b cf=%b ld=%h expected all zero", bus.core_status,
               bus.inst_fifo_rrequest, bus.operation_finish, bus.clear_finish, bus.log_fifo_wdata); errors++;
    end
    rstnn = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_copy();        run_tile(2'd0, 32'h1000, 32'h2000, 0, N-1, 0, 0, 0, -1); endtask
  task automatic test_transpose();   run_tile(2'd1, 32'h1000, 32'h2000, 0, N-1, 0, 0, 0, -1); endtask
  task automatic test_reverse();
    run_tile(2'd2, 32'h1100, 32'h2100, 0, N-1, 0, 0, 0, -1);
    run_tile(2'd3, 32'h1200, 32'h2200, 0, N-1, 0, 0, 0, -1);
  endtask
  task automatic test_early_last();  run_tile(2'd0, 32'h1300, 32'h2300, 100, 5, 0, 0, 0, -1); endtask
  task automatic test_stalls();      run_tile(2'd1, 32'hABCD0010, 32'h1234_5670, 7, N-1, 3, 3, 5, -1); endtask
  task automatic test_clear();       run_tile(2'd0, 32'h1400, 32'h2400, 33, N-1, 0, 0, 0, 4); endtask

  task automatic test_clear_idle();
    bus.clear_request = 1'b1;
    @(posedge clk); #1;
    bus.clear_request = 1'b0;
    checks++;
    if (bus.clear_finish !== 1'b1 || bus.core_status !== 2'b00) begin
      $display("[TB] FAIL clear_idle got cf=%b st=%b expected cf=1 st=00", bus.clear_finish, bus.core_status); errors++;
    end
    @(posedge clk); #1;
    checks++;
    if (bus.clear_finish !== 1'b0) begin
      $display("[TB] FAIL clear_idle_pulse got %b expected 0", bus.clear_finish); errors++;
    end
  endtask

  task automatic test_back_to_back();
    run_tile(2'd3, 32'h1500, 32'h2500, 200, N-1, 0, 0, 0, -1);
    bus.inst_fifo_rready = 1'b1;
    bus.inst_fifo_rdata  = {2'd2, 32'h2600, 32'h1600};
    @(posedge clk); #1;
    checks++;
    if (bus.inst_fifo_rrequest !== 1'b1) begin
      $display("[TB] FAIL b2b_pop got %b expected 1", bus.inst_fifo_rrequest); errors++;
    end
    run_tile(2'd2, 32'h1600, 32'h2600, 300, N-1, 1, 0, 0, -1);
    run_tile(2'd0, 32'h1700, 32'h2700, 400, N-1, 0, 2, 0, -1);
  endtask

  task automatic test_reset_mid();
    int k;
    bus.inst_fifo_rdata  = {2'd0, 32'h3000, 32'h3100};
    bus.inst_fifo_rready = 1'b1;
    k = 0;
    while (bus.inst_fifo_rrequest !== 1'b1 && k < 20) begin @(posedge clk); #1; k++; end
    @(posedge clk); #1;
    bus.inst_fifo_rready = 1'b0;
    bus.mi_inst_wready   = 1'b1;
    @(posedge clk); #1;
    bus.mi_inst_wready = 1'b0;
    bus.mi_row_wvalid  = 1'b1;
    bus.mi_row_wdata   = '1;
    repeat (2) begin @(posedge clk); #1; end
    rstnn = 1'b1;
    @(posedge clk); #1;
    rstnn = 1'b0;
    bus.mi_row_wvalid = 1'b0;
    log_count = 0;
    checks++;
    if (bus.core_status !== 2'b00 || bus.mi_row_wready !== 1'b0 || bus.clear_finish !== 1'b0) begin
      $display("[TB] FAIL reset_mid got st=%b wr=%b cf=%b expected 00 0 0", bus.core_status, bus.mi_row_wready, bus.clear_finish); errors++;
    end
    @(posedge clk); #1;
    checks++;
    if (bus.clear_finish !== 1'b0 || bus.core_status !== 2'b00) begin
      $display("[TB] FAIL reset_mid_after got cf=%b st=%b expected 0 00", bus.clear_finish, bus.core_status); errors++;
    end
    run_tile(2'd1, 32'h3200, 32'h3300, 5, N-1, 0, 0, 0, -1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at %0t expected completion", $time);
    $fatal(1);
  end

  initial begin
    rstnn = 1'b1;
    bus.clear_request     = 1'b0;
    bus.inst_fifo_rready  = 1'b0;
    bus.inst_fifo_rdata   = '0;
    bus.log_fifo_wready   = 1'b1;
    bus.mi_inst_wready    = 1'b0;
    bus.mi_execute_finish = 1'b0;
    bus.mi_row_wvalid     = 1'b0;
    bus.mi_row_wlast      = 1'b0;
    bus.mi_row_wdata      = '0;
    bus.mo_inst_wready    = 1'b0;
    bus.mo_execute_finish = 1'b0;
    bus.mo_row_rvalid     = 1'b0;
    bus.mo_row_rlast      = 1'b0;
    test_reset();
    test_copy();
    test_transpose();
    test_reverse();
    test_early_last();
    test_stalls();
    test_clear();
    test_clear_idle();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
